// File: rtl/lcd_panel_writer_pkg.sv
// ---------------------------------------------------------------------------
// lcd_panel_writer_pkg
//   Shared constants for the dual-controller 128x64 LCD panel writer:
//   panel command opcodes, chip-select patterns, FSM state encodings, the
//   bus-word struct the FSM hands to the strobe generator, and a helper that
//   builds the set-page command.
// ---------------------------------------------------------------------------
package lcd_panel_writer_pkg;

  // Panel command opcodes (written with lcd_di = 0).
  localparam logic [7:0] CMD_DISPLAY_ON = 8'h3F;  // display on
  localparam logic [7:0] CMD_START_LINE = 8'hC0;  // start line 0
  localparam logic [7:0] CMD_SET_PAGE   = 8'hB8;  // page address, OR'ed with page
  localparam logic [7:0] CMD_SET_COL    = 8'h40;  // column address 0

  // Chip-select patterns (active-high, bit0 = left half, bit1 = right half).
  localparam logic [1:0] CS_NONE = 2'b00;
  localparam logic [1:0] CS_LEFT = 2'b01;
  localparam logic [1:0] CS_BOTH = 2'b11;

  // Frame geometry.
  localparam logic [5:0] COL_LAST  = 6'd63;
  localparam logic [2:0] PAGE_LAST = 3'd7;

  // Top-level FSM state encodings.
  localparam logic [2:0] ST_RESET      = 3'd0;
  localparam logic [2:0] ST_INIT_ON    = 3'd1;
  localparam logic [2:0] ST_INIT_START = 3'd2;
  localparam logic [2:0] ST_SET_PAGE   = 3'd3;
  localparam logic [2:0] ST_SET_COL    = 3'd4;
  localparam logic [2:0] ST_REQ        = 3'd5;
  localparam logic [2:0] ST_WAIT       = 3'd6;
  localparam logic [2:0] ST_WR_DATA    = 3'd7;

  // One panel bus transfer as seen by the strobe generator.
  typedef struct packed {
    logic       di;    // 0 = command, 1 = display data
    logic [1:0] cs;    // chip selects
    logic [7:0] data;  // byte driven on lcd_data
  } bus_word_t;

  // Set-page command for a given page number.
  function automatic logic [7:0] page_cmd(input logic [2:0] page);
    return CMD_SET_PAGE | {5'b00000, page};
  endfunction

endpackage

// File: rtl/lcd_panel_writer_bus.sv
// ---------------------------------------------------------------------------
// lcd_bus_writer
//   Generates one panel bus write per start request:
//     1 setup cycle (lcd_e = 0), E_HALF cycles lcd_e = 1, E_HALF cycles
//     lcd_e = 0.  lcd_cs / lcd_di / lcd_data are captured on start and held
//     for the whole transfer (and afterwards, until the next start).
//
//   Parameters
//     E_HALF   clk cycles per lcd_e high phase and per low phase (>= 1)
//   Ports
//     clk, rst_n   clock, asynchronous active-low reset
//     start        request a write; honoured only while busy = 0
//     di, cs, wr_byte  transfer payload
//     busy         a write is in progress
//     done         single-cycle pulse in the last cycle of a write
//     lcd_cs, lcd_di, lcd_data, lcd_e   panel bus
// ---------------------------------------------------------------------------
module lcd_bus_writer
  import lcd_panel_writer_pkg::*;
#(
  parameter int E_HALF = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       di,
  input  logic [1:0] cs,
  input  logic [7:0] wr_byte,
  output logic       busy,
  output logic       done,
  output logic [1:0] lcd_cs,
  output logic       lcd_di,
  output logic [7:0] lcd_data,
  output logic       lcd_e
);

  // Phase counter runs 0 (setup) .. 2*E_HALF (last low cycle).
  localparam int            CW    = $clog2(2 * E_HALF + 1);
  localparam logic [CW-1:0] LAST  = CW'(2 * E_HALF);
  localparam logic [CW-1:0] E_LIM = CW'(E_HALF);

  logic [CW-1:0] cnt;

  assign done = busy && (cnt == LAST);

  // lcd_e is a flop with asynchronous reset, so asserting rst_n mid-write
  // drops the strobe immediately rather than at the next clock edge.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; mixing in = here would create order-dependent logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      cnt      <= '0;
      lcd_e    <= 1'b0;
      lcd_cs   <= CS_NONE;
      lcd_di   <= 1'b0;
      lcd_data <= 8'h00;
    end else if (!busy) begin
      if (start) begin
        busy     <= 1'b1;
        cnt      <= '0;
        lcd_e    <= 1'b0;
        lcd_cs   <= cs;
        lcd_di   <= di;
        lcd_data <= wr_byte;
      end
    end else if (cnt == LAST) begin
      busy  <= 1'b0;
      cnt   <= '0;
      lcd_e <= 1'b0;
    end else begin
      cnt   <= cnt + CW'(1);
      // Next count lands in 1..E_HALF exactly when the current one is
      // below E_HALF: that is the high phase.
      lcd_e <= (cnt < E_LIM);
    end
  end

endmodule

// File: rtl/lcd_panel_writer.sv
// ---------------------------------------------------------------------------
// lcd_panel_writer
//   Streams a 512-byte frame (8 pages x 64 columns, bit 0 = top row of the
//   page) into the left controller of a KS0108-style LCD.  After reset the
//   panel reset line is held low for RST_CYCLES, the panel is initialised
//   (display on, start line 0), and then the frame is refreshed forever:
//   each page starts with set-page and set-column commands, followed by 64
//   data bytes fetched one at a time through a data_req / data_valid
//   handshake.  The panel auto-increments the column, so only one set-column
//   command is issued per page.
//
//   Parameters
//     E_HALF       clk cycles per lcd_e high phase and per low phase (>= 1)
//     RST_CYCLES   clk cycles lcd_rst is held low after reset release
//   Ports
//     clk, rst_n   clock, asynchronous active-low reset
//     data_in      pixel byte, accepted only in the cycle after data_req
//     data_valid   data_in is valid this cycle
//     data_req     single-cycle request for the next pixel byte
//     lcd_rst      panel reset, active-low
//     lcd_cs       chip selects (bit0 left, bit1 right)
//     lcd_rw       always 0, the bus is write-only
//     lcd_di       0 = command, 1 = display data
//     lcd_data     panel data bus
//     lcd_e        panel enable strobe
//     frame_done   one-cycle pulse after the last byte of a frame is written
// ---------------------------------------------------------------------------
module lcd_panel_writer
  import lcd_panel_writer_pkg::*;
#(
  parameter int E_HALF     = 4,
  parameter int RST_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_req,
  output logic       lcd_rst,
  output logic [1:0] lcd_cs,
  output logic       lcd_rw,
  output logic       lcd_di,
  output logic [7:0] lcd_data,
  output logic       lcd_e,
  output logic       frame_done
);

  localparam int             RCW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

  logic [2:0]     state;
  logic [RCW-1:0] rst_cnt;
  logic [2:0]     page;
  logic [5:0]     col;
  logic [7:0]     pix_q;      // byte accepted in WAIT, written in WR_DATA
  logic           launched;   // current write state has already issued start

  bus_word_t      cmd;
  logic           is_write;
  logic           start;
  logic           wr_busy;
  logic           wr_done;

  assign lcd_rw   = 1'b0;
  assign data_req = (state == ST_REQ);

  // Payload for the write belonging to the current state.
  // NOTE: every output of an always_comb gets a default before the case so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    cmd      = '{di: 1'b0, cs: CS_NONE, data: 8'h00};
    is_write = 1'b1;
    case (state)
      ST_INIT_ON:    cmd = '{di: 1'b0, cs: CS_BOTH, data: CMD_DISPLAY_ON};
      ST_INIT_START: cmd = '{di: 1'b0, cs: CS_BOTH, data: CMD_START_LINE};
      ST_SET_PAGE:   cmd = '{di: 1'b0, cs: CS_LEFT, data: page_cmd(page)};
      ST_SET_COL:    cmd = '{di: 1'b0, cs: CS_LEFT, data: CMD_SET_COL};
      ST_WR_DATA:    cmd = '{di: 1'b1, cs: CS_LEFT, data: pix_q};
      default:       is_write = 1'b0;
    endcase
  end

  // A write state fires its transfer once, in its first cycle; the state
  // then waits for the writer's done pulse before moving on.
  assign start = is_write && !launched && !wr_busy;

  lcd_bus_writer #(
    .E_HALF (E_HALF)
  ) u_bus (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .di       (cmd.di),
    .cs       (cmd.cs),
    .wr_byte  (cmd.data),
    .busy     (wr_busy),
    .done     (wr_done),
    .lcd_cs   (lcd_cs),
    .lcd_di   (lcd_di),
    .lcd_data (lcd_data),
    .lcd_e    (lcd_e)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RESET;
      rst_cnt    <= '0;
      lcd_rst    <= 1'b0;
      page       <= 3'd0;
      col        <= 6'd0;
      pix_q      <= 8'h00;
      launched   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (start) begin
        launched <= 1'b1;
      end else if (wr_done) begin
        launched <= 1'b0;
      end

      case (state)
        ST_RESET: begin
          if (rst_cnt == RST_LAST) begin
            lcd_rst <= 1'b1;
            state   <= ST_INIT_ON;
          end else begin
            rst_cnt <= rst_cnt + RCW'(1);
          end
        end

        ST_INIT_ON: begin
          if (wr_done) state <= ST_INIT_START;
        end

        ST_INIT_START: begin
          if (wr_done) state <= ST_SET_PAGE;
        end

        ST_SET_PAGE: begin
          if (wr_done) state <= ST_SET_COL;
        end

        ST_SET_COL: begin
          if (wr_done) state <= ST_REQ;
        end

        // data_req is high for this single cycle only.
        ST_REQ: state <= ST_WAIT;

        // The only cycle in which data_valid is honoured; a miss re-requests,
        // so each data_req pulse yields at most one byte.
        ST_WAIT: begin
          if (data_valid) begin
            pix_q <= data_in;
            state <= ST_WR_DATA;
          end else begin
            state <= ST_REQ;
          end
        end

        ST_WR_DATA: begin
          if (wr_done) begin
            col <= col + 6'd1;
            if (col == COL_LAST) begin
              page  <= page + 3'd1;
              state <= ST_SET_PAGE;
              if (page == PAGE_LAST) frame_done <= 1'b1;
            end else begin
              state <= ST_REQ;
            end
          end
        end

        default: state <= ST_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_panel_writer.sv
// ---------------------------------------------------------------------------
// tb_lcd_panel_writer
//   Two instances share the clock: dut_a with default timing (E_HALF=4,
//   RST_CYCLES=16) and dut_b with E_HALF=1, RST_CYCLES=4.  A per-instance
//   bus monitor captures every write on the rising edge of lcd_e and checks
//   it against the expected command/data stream, plus strobe width and bus
//   stability.  A per-instance responder answers data_req with bytes
//   0,1,2,... (mod 256), optionally ignoring the first few requests.
// ---------------------------------------------------------------------------
module tb_lcd_panel_writer;

  localparam int PAGE_WR  = 66;           // B8|p, 40, 64 data bytes
  localparam int FRAME_WR = 8 * PAGE_WR;  // writes per frame after init

  typedef struct {
    logic        e_q;
    logic [10:0] word_q;   // {di, cs, data} seen on the previous sample
    int          hi;
    int          lo;
    logic        bad;
    int          idx;      // writes captured since reset
  } mon_t;

  typedef struct {
    logic       en;
    int         skip;
    logic       prev_req;
    logic       drove;
    logic [7:0] nxt;
  } resp_t;

  logic clk;

  logic       rst_n_a, data_valid_a, data_req_a, lcd_rst_a, lcd_rw_a;
  logic       lcd_di_a, lcd_e_a, frame_done_a;
  logic [7:0] data_in_a, lcd_data_a;
  logic [1:0] lcd_cs_a;

  logic       rst_n_b, data_valid_b, data_req_b, lcd_rst_b, lcd_rw_b;
  logic       lcd_di_b, lcd_e_b, frame_done_b;
  logic [7:0] data_in_b, lcd_data_b;
  logic [1:0] lcd_cs_b;

  mon_t  mon_a, mon_b;
  resp_t resp_a, resp_b;
  int    fd_a, fd_b;
  int    n_checks, n_errors;

  lcd_panel_writer #(.E_HALF(4), .RST_CYCLES(16)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n_a),
    .data_in    (data_in_a),
    .data_valid (data_valid_a),
    .data_req   (data_req_a),
    .lcd_rst    (lcd_rst_a),
    .lcd_cs     (lcd_cs_a),
    .lcd_rw     (lcd_rw_a),
    .lcd_di     (lcd_di_a),
    .lcd_data   (lcd_data_a),
    .lcd_e      (lcd_e_a),
    .frame_done (frame_done_a)
  );

  lcd_panel_writer #(.E_HALF(1), .RST_CYCLES(4)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n_b),
    .data_in    (data_in_b),
    .data_valid (data_valid_b),
    .data_req   (data_req_b),
    .lcd_rst    (lcd_rst_b),
    .lcd_cs     (lcd_cs_b),
    .lcd_rw     (lcd_rw_b),
    .lcd_di     (lcd_di_b),
    .lcd_data   (lcd_data_b),
    .lcd_e      (lcd_e_b),
    .frame_done (frame_done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Expected {di, cs, data} of the idx-th write after reset.
  function automatic logic [10:0] exp_word(input int idx);
    int j, p, r;
    if (idx == 0) return {1'b0, 2'b11, 8'h3F};
    if (idx == 1) return {1'b0, 2'b11, 8'hC0};
    j = (idx - 2) % FRAME_WR;
    p = j / PAGE_WR;
    r = j % PAGE_WR;
    if (r == 0) return {1'b0, 2'b01, 8'hB8 | 8'(p)};
    if (r == 1) return {1'b0, 2'b01, 8'h40};
    return {1'b1, 2'b01, 8'((p * 64 + r - 2) % 256)};
  endfunction

  task automatic mon_step(input string tag, input int eh, input logic rn, input logic e,
                          input logic [10:0] w, inout mon_t m);
    if (!rn) begin
      m = '{e_q: 1'b0, word_q: '0, hi: 0, lo: 0, bad: 1'b0, idx: 0};
    end else begin
      if (e && !m.e_q) begin
        check({tag, " setup"}, 32'(m.word_q), 32'(exp_word(m.idx)));
        check({tag, " word"}, 32'(w), 32'(exp_word(m.idx)));
        m.idx++;
        m.hi  = 1;
        m.lo  = 0;
        m.bad = 1'b0;
      end else if (e) begin
        m.hi++;
        if (w != m.word_q) m.bad = 1'b1;
      end else if (m.e_q) begin
        if (w != m.word_q) m.bad = 1'b1;
        check({tag, " e_high"}, 32'(m.hi), 32'(eh));
        check({tag, " stable"}, 32'(m.bad), 32'(0));
        m.lo = 1;
      end else if (m.lo > 0) begin
        if (w != m.word_q) begin
          check({tag, " hold"}, 32'(m.lo >= eh), 32'(1));
          m.lo = 0;
        end else begin
          m.lo++;
        end
      end
      m.e_q    = e;
      m.word_q = w;
    end
  endtask

  // Answers in the WAIT cycle (request seen on the previous sample).
  task automatic resp_step(input logic rn, input logic req, inout resp_t r,
                           inout logic dv, inout logic [7:0] din);
    if (!rn) begin
      r.prev_req = 1'b0;
      r.drove    = 1'b0;
      r.nxt      = 8'h00;
      r.skip     = 0;
      if (r.en) dv = 1'b0;
    end else begin
      if (r.en) begin
        if (r.drove) begin
          dv      = 1'b0;
          r.drove = 1'b0;
        end
        if (r.prev_req && !req) begin
          if (r.skip > 0) begin
            r.skip--;
          end else begin
            dv      = 1'b1;
            din     = r.nxt;
            r.nxt   = r.nxt + 8'd1;
            r.drove = 1'b1;
          end
        end
      end
      r.prev_req = req;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon_step("A", 4, rst_n_a, lcd_e_a, {lcd_di_a, lcd_cs_a, lcd_data_a}, mon_a);
    if (rst_n_a && frame_done_a) begin
      fd_a++;
      check("A frame_done pos", 32'((mon_a.idx - 2) % FRAME_WR), 32'(0));
    end
    resp_step(rst_n_a, data_req_a, resp_a, data_valid_a, data_in_a);
    mon_step("B", 1, rst_n_b, lcd_e_b, {lcd_di_b, lcd_cs_b, lcd_data_b}, mon_b);
    if (rst_n_b && frame_done_b) begin
      fd_b++;
      check("B frame_done pos", 32'((mon_b.idx - 2) % FRAME_WR), 32'(0));
    end
    resp_step(rst_n_b, data_req_b, resp_b, data_valid_b, data_in_b);
  endtask

  initial begin
    int         n;
    logic [5:0] pat;
    logic       e_before;

    n_checks     = 0;
    n_errors     = 0;
    fd_a         = 0;
    fd_b         = 0;
    rst_n_a      = 1'b0;
    rst_n_b      = 1'b0;
    data_valid_a = 1'b0;
    data_valid_b = 1'b0;
    data_in_a    = 8'h00;
    data_in_b    = 8'h00;
    resp_a       = '{en: 1'b0, skip: 0, prev_req: 1'b0, drove: 1'b0, nxt: 8'h00};
    resp_b       = '{en: 1'b0, skip: 0, prev_req: 1'b0, drove: 1'b0, nxt: 8'h00};

    repeat (3) tick();

    // Outputs while held in reset.
    check("A rst data_req",   32'(data_req_a),   32'(0));
    check("A rst lcd_rst",    32'(lcd_rst_a),    32'(0));
    check("A rst lcd_cs",     32'(lcd_cs_a),     32'(0));
    check("A rst lcd_rw",     32'(lcd_rw_a),     32'(0));
    check("A rst lcd_di",     32'(lcd_di_a),     32'(0));
    check("A rst lcd_data",   32'(lcd_data_a),   32'(0));
    check("A rst lcd_e",      32'(lcd_e_a),      32'(0));
    check("A rst frame_done", 32'(frame_done_a), 32'(0));

    // Panel reset pulse length after release.
    rst_n_a = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!lcd_rst_a && n < 100);
    check("A lcd_rst low cycles", 32'(n), 32'(16));

    // Spurious data_valid while SET_COL is on the bus.
    n = 0;
    while (lcd_data_a != 8'h40 && n < 400) begin
      tick();
      n++;
    end
    check("A set_col on bus", 32'(lcd_data_a), 32'h40);
    check("A writes before set_col", 32'(mon_a.idx), 32'(3));
    data_valid_a = 1'b1;
    data_in_a    = 8'hEE;
    repeat (3) tick();
    data_valid_a = 1'b0;

    // Delayed responder: answer only the third request.
    resp_a.en   = 1'b1;
    resp_a.skip = 2;
    n = 0;
    while (!data_req_a && n < 400) begin
      tick();
      n++;
    end
    check("A first data_req", 32'(data_req_a), 32'(1));
    pat = 6'b000001;
    for (int i = 0; i < 5; i++) begin
      tick();
      pat = {pat[4:0], data_req_a};
    end
    check("A data_req alternation", 32'(pat), 32'(6'b101010));

    // Full frame followed by the start of the next one.
    n = 0;
    while (mon_a.idx < 2 + FRAME_WR + 2 && n < 20000) begin
      tick();
      n++;
    end
    check("A frame complete", 32'(mon_a.idx >= 2 + FRAME_WR + 2), 32'(1));
    check("A frame_done count", 32'(fd_a), 32'(1));

    // Reset during lcd_e high of the column-30 write of the second frame.
    n = 0;
    while (mon_a.idx != 2 + FRAME_WR + 2 + 31 && n < 2000) begin
      tick();
      n++;
    end
    e_before = lcd_e_a;
    check("A e high before reset", 32'(e_before), 32'(1));
    rst_n_a = 1'b0;
    #1;
    check("A e async drop", 32'(lcd_e_a), 32'(0));
    check("A cs in reset", 32'(lcd_cs_a), 32'(0));
    check("A data_req in reset", 32'(data_req_a), 32'(0));
    repeat (3) tick();
    check("A lcd_rst in reset", 32'(lcd_rst_a), 32'(0));
    check("A frame_done in reset", 32'(frame_done_a), 32'(0));
    rst_n_a = 1'b1;
    n = 0;
    while (mon_a.idx < 10 && n < 2000) begin
      tick();
      n++;
    end
    check("A restart sequence", 32'(mon_a.idx >= 10), 32'(1));

    // Fast-strobe instance: whole frame with an immediate responder.
    resp_b.en = 1'b1;
    rst_n_b   = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!lcd_rst_b && n < 100);
    check("B lcd_rst low cycles", 32'(n), 32'(4));
    n = 0;
    while (mon_b.idx < 2 + FRAME_WR + 2 && n < 20000) begin
      tick();
      n++;
    end
    check("B frame complete", 32'(mon_b.idx >= 2 + FRAME_WR + 2), 32'(1));
    check("B frame_done count", 32'(fd_b), 32'(1));
    check("B lcd_rw", 32'(lcd_rw_b), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_panel_writer.md
LCD_PANEL_WRITER -- requirements
Module: lcd_panel_writer

Interface
REQ-001 SHALL have parameter E_HALF, default 4: clk cycles per lcd_e high phase and per low phase (min 1).
REQ-002 SHALL have parameter RST_CYCLES, default 16: clk cycles lcd_rst is held low after reset release.
REQ-003 SHALL have port clk, input, 1: clock, rising-edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port data_in, input, 8: pixel byte, bit 0 = top row of the page.
REQ-006 SHALL have port data_valid, input, 1: data_in valid this cycle.
REQ-007 SHALL have port data_req, output, 1: single-cycle request for the next pixel byte.
REQ-008 SHALL have port lcd_rst, output, 1: panel reset, active-low.
REQ-009 SHALL have port lcd_cs, output, 2: chip selects, active-high; bit0 left half, bit1 right half.
REQ-010 SHALL have port lcd_rw, output, 1: always 0 (write-only bus).
REQ-011 SHALL have port lcd_di, output, 1: 0 command, 1 display data.
REQ-012 SHALL have port lcd_data, output, 8: panel data bus.
REQ-013 SHALL have port lcd_e, output, 1: panel enable strobe.
REQ-014 SHALL have port frame_done, output, 1: one-cycle pulse after byte 512 of a frame is written.

Function
REQ-015 SHALL run this FSM: RESET -> INIT_ON -> INIT_START -> SET_PAGE -> SET_COL -> REQ -> WAIT -> WR_DATA -> (REQ | SET_PAGE).
REQ-016 RESET SHALL hold lcd_rst=0 for RST_CYCLES cycles, then drive lcd_rst=1 until the next rst_n assertion.
REQ-017 Each bus write SHALL take 2*E_HALF+1 cycles: 1 setup cycle (lcd_e=0), E_HALF cycles lcd_e=1, then E_HALF cycles lcd_e=0; lcd_data, lcd_di and lcd_cs SHALL stay stable for all of them.
REQ-018 INIT_ON SHALL write command 0x3F and INIT_START SHALL write command 0xC0, both with lcd_cs=2'b11.
REQ-019 SET_PAGE SHALL write command 0xB8|page, SET_COL SHALL write command 0x40, and WR_DATA SHALL write the latched byte with lcd_di=1; all three SHALL use lcd_cs=2'b01.
REQ-020 In REQ, data_req SHALL be 1 for exactly one cycle; in the following WAIT cycle data_req SHALL be 0.
REQ-021 If data_valid=1 in WAIT, data_in SHALL be latched and the FSM SHALL go to WR_DATA; otherwise it SHALL return to REQ. This gives data_req a strictly alternating pulse pattern and exactly one byte per request.
REQ-022 data_valid in any state other than WAIT SHALL be ignored; the byte SHALL be discarded and no counter SHALL change.
REQ-023 The 6-bit column counter SHALL increment after each WR_DATA; below 63 the FSM SHALL go to REQ.
REQ-024 When column 63 is written, the column SHALL wrap to 0, the 3-bit page counter SHALL increment, and the FSM SHALL go to SET_PAGE.
REQ-025 When page 7, column 63 is written, page SHALL wrap to 0, frame_done SHALL pulse for 1 cycle on the cycle WR_DATA ends, and refresh SHALL continue without re-running init.
REQ-026 The panel column auto-increments, so SET_COL SHALL be issued only after SET_PAGE.

Reset
REQ-027 While rst_n=0: data_req=0, lcd_rst=0, lcd_cs=2'b00, lcd_rw=0, lcd_di=0, lcd_data=8'h00, lcd_e=0, frame_done=0, page=0, column=0, state=RESET.
REQ-028 rst_n asserted mid-write SHALL drop lcd_e to 0 immediately (asynchronously); after release the full RESET/init sequence SHALL rerun from page 0.

Structure
REQ-029 The command constants (0x3F, 0xC0, 0xB8, 0x40) and the FSM state encodings SHALL live in the shared global include/package.
REQ-030 Strobe timing SHALL be implemented in one sub-module, lcd_bus_writer: inputs start, di, cs, byte; outputs busy plus the lcd_* bus; the top FSM advances on its done pulse.

Verification
REQ-031 Reset/init: release rst_n -> lcd_rst low for 16 cycles, then 0x3F and 0xC0 with cs=11 and di=0, each with lcd_e high for exactly 4 cycles.
REQ-032 Delayed responder: data_valid 5 cycles after the first data_req -> data_req pulses on alternating cycles until then, and exactly one data write of that byte with di=1 follows.
REQ-033 Full frame: responder returns bytes 0..511 mod 256 -> commands B8..BF each followed by 40, 512 data writes in order, one frame_done pulse, then B8 again.
REQ-034 Spurious data_valid=1 during SET_COL -> no extra write and no change to the column count.
REQ-035 rst_n asserted during lcd_e high of the column-30 write -> lcd_e=0 at once; after release the sequence restarts with 3F, C0, B8, 40.
REQ-036 E_HALF=1 -> each write is 3 cycles and the frame is still correct.
